vram_port_arbiter: RTL and testbench
====================================

VRAM_PORT_ARBITER -- requirements
Module: vram_port_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 10, word-address width of the VRAM.
REQ-002 Parameter: DEPTH, default 600, number of valid 32-bit VRAM words (0x000-0x257).
REQ-003 Parameter: STARVE_MAX, default 4, consecutive scan-won conflicts before Avalon is forced a grant.
REQ-004 Clocking: one clock; reset is asynchronous and active-low.
REQ-005 Port: CLK  in  1  sole clock (50 MHz system/pixel domain).
REQ-006 Port: RESET_N  in  1  asynchronous active-low reset.
REQ-007 Port: AVL_CS, AVL_READ, AVL_WRITE  in  1 each  Avalon-MM slave strobes.
REQ-008 Port: AVL_ADDR  in  ADDR_W  Avalon word address.
REQ-009 Port: AVL_BYTE_EN  in  4  Avalon byte enables.
REQ-010 Port: AVL_WRITEDATA  in  32  Avalon write data.
REQ-011 Port: AVL_READDATA  out  32  Avalon read data, valid when AVL_WAITREQUEST=0 on a read.
REQ-012 Port: AVL_WAITREQUEST  out  1  Avalon stall.
REQ-013 Port: SCAN_REQ  in  1  scan-out fetcher request, held until SCAN_ACK.
REQ-014 Port: SCAN_ADDR  in  ADDR_W  scan fetch word address.
REQ-015 Port: SCAN_ACK  out  1  one-cycle pulse, scan request issued to RAM.
REQ-016 Port: SCAN_VALID  out  1  one-cycle pulse, SCAN_DATA valid.
REQ-017 Port: SCAN_DATA  out  32  fetched word.
REQ-018 Port: RAM_ADDR  out  ADDR_W  single-port VRAM address.
REQ-019 Port: RAM_WREN, RAM_RDEN  out  1 each  VRAM write/read strobes.
REQ-020 Port: RAM_BYTE_EN  out  4; RAM_WDATA  out  32; RAM_RDATA  in  32 (registered, 1-cycle read latency).

Function
REQ-021 At most one RAM access (RAM_RDEN or RAM_WREN) SHALL issue per cycle.
REQ-022 Avalon request pending = AVL_CS & (AVL_READ | AVL_WRITE); AVL_WAITREQUEST SHALL be 1 while pending except in its completion cycle, and 0 when not pending.
REQ-023 Return FSM states: ST_IDLE (nothing returning), ST_SCAN_RET (scan read data on RAM_RDATA), ST_AVL_RET (Avalon read data on RAM_RDATA); next state set by this cycle's issued read, else ST_IDLE.
REQ-024 Grant: scan wins a conflict unless starve count == STARVE_MAX, then Avalon wins; Avalon is ineligible in ST_AVL_RET (its read is completing).
REQ-025 Starve counter (3 bits) SHALL increment on each cycle an eligible Avalon request loses to scan, saturate at STARVE_MAX, clear when Avalon is granted or not pending.
REQ-026 Avalon write grant: RAM_WREN=1, RAM_ADDR/BYTE_EN/WDATA from Avalon, AVL_WAITREQUEST=0 same cycle (zero wait states when uncontended).
REQ-027 Avalon read grant: RAM_RDEN=1 that cycle; next cycle (ST_AVL_RET) AVL_READDATA=RAM_RDATA, AVL_WAITREQUEST=0 (one wait state).
REQ-028 Scan grant: RAM_RDEN=1, SCAN_ACK=1 same cycle; next cycle SCAN_VALID=1, SCAN_DATA=RAM_RDATA; SCAN_DATA holds until next SCAN_VALID.
REQ-029 Scan and Avalon accesses may interleave back-to-back: scan issue permitted in ST_AVL_RET and vice versa, full RAM throughput.
REQ-030 Avalon address >= DEPTH: no RAM strobe, completes in grant cycle with AVL_WAITREQUEST=0, read returns 32'h0, write discarded.
REQ-031 Avalon write with AVL_BYTE_EN=4'b0000: completes normally, RAM_WREN=0.
REQ-032 Scan address >= DEPTH: SCAN_ACK issued, no RAM strobe, SCAN_VALID next cycle with SCAN_DATA=32'h0.
REQ-033 AVL_READ and AVL_WRITE both set: treated as write.
REQ-034 AVL_READDATA SHALL be 32'h0 when not completing a read.

Reset
REQ-035 RESET_N low SHALL asynchronously force ST_IDLE, starve count 0, SCAN_VALID 0, SCAN_DATA 32'h0; combinational outputs follow (SCAN_ACK, RAM strobes 0, AVL_WAITREQUEST 1 if pending).
REQ-036 Reset mid-access SHALL discard any in-flight return; no SCAN_VALID or Avalon completion for it after release.

Structure
REQ-037 Shared package vram_pkg SHALL hold the return-state enum, VRAM_DEPTH (600) and VRAM_ADDR_W (10) constants.
REQ-038 No sub-module required; the VRAM instance stays outside this block.

Verification
REQ-039 Write-only: Avalon write addr 0x005 data 32'hDEADBEEF BE 4'hF, no scan -> RAM_WREN same cycle, WAITREQUEST 0 same cycle; later read of 0x005 returns 32'hDEADBEEF after 1 wait state.
REQ-040 Continuous SCAN_REQ + held Avalon read 0x010 -> Avalon granted on 5th conflict cycle (STARVE_MAX=4), completes next cycle; scan ACK resumes immediately.
REQ-041 Interleave: scan read 0x000 then Avalon read 0x001 in consecutive cycles -> SCAN_VALID and AVL completion on successive cycles, correct data each, one RAM access per cycle.
REQ-042 Out-of-range: Avalon read 0x258 -> no RAM strobe, WAITREQUEST 0 in grant cycle, READDATA 32'h0; scan 0x3FF -> SCAN_VALID with 32'h0.
REQ-043 Reset: assert RESET_N low in cycle after scan issue -> no SCAN_VALID after release, state ST_IDLE, counter 0.

Source files
------------

// File: rtl/vram_pkg.sv
// Shared VRAM constants and the read-return state encoding.
// Imported by the VRAM port arbiter and its testbench.
package vram_pkg;

   localparam int VRAM_DEPTH  = 600;
   localparam int VRAM_ADDR_W = 10;

   // Which requester owns the data on RAM_RDATA this cycle.
   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_SCAN_RET = 2'd1,
      ST_AVL_RET  = 2'd2
   } ret_st_e;

endpackage

// File: rtl/vram_port_arbiter.sv
// Arbitrates a single-port VRAM between an Avalon-MM slave and the
// scan-out fetcher; scan has priority with a starvation guard for Avalon.
// Ports:
//   CLK, RESET_N          : clock, async active-low reset
//   AVL_*                 : Avalon-MM slave (cs/read/write/addr/be/wdata,
//                           readdata/waitrequest)
//   SCAN_REQ/ADDR         : fetch request, held until SCAN_ACK
//   SCAN_ACK/VALID/DATA   : issue pulse, return pulse and fetched word
//   RAM_*                 : VRAM port, registered read data (1-cycle)
module vram_port_arbiter
   import vram_pkg::*;
#(
   parameter int ADDR_W     = VRAM_ADDR_W,
   parameter int DEPTH      = VRAM_DEPTH,
   parameter int STARVE_MAX = 4
)(
   input  logic              CLK,
   input  logic              RESET_N,
   input  logic              AVL_CS,
   input  logic              AVL_READ,
   input  logic              AVL_WRITE,
   input  logic [ADDR_W-1:0] AVL_ADDR,
   input  logic [3:0]        AVL_BYTE_EN,
   input  logic [31:0]       AVL_WRITEDATA,
   output logic [31:0]       AVL_READDATA,
   output logic              AVL_WAITREQUEST,
   input  logic              SCAN_REQ,
   input  logic [ADDR_W-1:0] SCAN_ADDR,
   output logic              SCAN_ACK,
   output logic              SCAN_VALID,
   output logic [31:0]       SCAN_DATA,
   output logic [ADDR_W-1:0] RAM_ADDR,
   output logic              RAM_WREN,
   output logic              RAM_RDEN,
   output logic [3:0]        RAM_BYTE_EN,
   output logic [31:0]       RAM_WDATA,
   input  logic [31:0]       RAM_RDATA
);

   localparam logic [ADDR_W:0] LP_DEPTH = DEPTH[ADDR_W:0];
   localparam logic [2:0]      LP_SMAX  = STARVE_MAX[2:0];

   ret_st_e     r_state;
   ret_st_e     w_nxt;
   logic        r_ret_oor;
   logic        w_nxt_oor;
   logic [2:0]  r_starve;
   logic [31:0] r_scan_data;

   logic        w_avl_pend;
   logic        w_avl_elig;
   logic        w_avl_oor;
   logic        w_scn_oor;
   logic        w_starved;
   logic        w_avl_gnt;
   logic        w_scn_gnt;
   logic        w_scan_ret;
   logic [31:0] w_scan_word;

   assign w_avl_pend = AVL_CS & (AVL_READ | AVL_WRITE);
   assign w_avl_oor  = {1'b0, AVL_ADDR} >= LP_DEPTH;
   assign w_scn_oor  = {1'b0, SCAN_ADDR} >= LP_DEPTH;
   // Avalon sits out while its own read data is being returned.
   assign w_avl_elig = w_avl_pend & (r_state != ST_AVL_RET);
   assign w_starved  = (r_starve == LP_SMAX);
   // No grants while reset is held, so strobes stay quiet.
   assign w_avl_gnt  = RESET_N & w_avl_elig & (~SCAN_REQ | w_starved);
   assign w_scn_gnt  = RESET_N & SCAN_REQ & ~w_avl_gnt;

   assign w_scan_ret  = (r_state == ST_SCAN_RET);
   assign w_scan_word = r_ret_oor ? 32'h0 : RAM_RDATA;
   assign SCAN_VALID  = w_scan_ret;
   assign SCAN_DATA   = w_scan_ret ? w_scan_word : r_scan_data;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_state   <= ST_IDLE;
         r_ret_oor <= 1'b0;
      end else begin
         r_state   <= w_nxt;
         r_ret_oor <= w_nxt_oor;
      end
   end

   always_comb begin
      w_nxt           = ST_IDLE;
      w_nxt_oor       = 1'b0;
      RAM_ADDR        = '0;
      RAM_WREN        = 1'b0;
      RAM_RDEN        = 1'b0;
      RAM_BYTE_EN     = 4'h0;
      RAM_WDATA       = 32'h0;
      SCAN_ACK        = 1'b0;
      AVL_WAITREQUEST = w_avl_pend;
      AVL_READDATA    = 32'h0;

      if (r_state == ST_AVL_RET && w_avl_pend) begin
         AVL_WAITREQUEST = 1'b0;
         AVL_READDATA    = RAM_RDATA;
      end

      if (w_avl_gnt) begin
         RAM_ADDR    = AVL_ADDR;
         RAM_BYTE_EN = AVL_BYTE_EN;
         RAM_WDATA   = AVL_WRITEDATA;
         // Read+write together is handled as a write.
         if (AVL_WRITE) begin
            AVL_WAITREQUEST = 1'b0;
            RAM_WREN        = ~w_avl_oor & (|AVL_BYTE_EN);
         end else if (w_avl_oor) begin
            AVL_WAITREQUEST = 1'b0;
         end else begin
            RAM_RDEN = 1'b1;
            w_nxt    = ST_AVL_RET;
         end
      end else if (w_scn_gnt) begin
         SCAN_ACK  = 1'b1;
         RAM_ADDR  = SCAN_ADDR;
         RAM_RDEN  = ~w_scn_oor;
         w_nxt     = ST_SCAN_RET;
         w_nxt_oor = w_scn_oor;
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_starve <= 3'd0;
      end else if (!w_avl_pend || w_avl_gnt) begin
         r_starve <= 3'd0;
      end else if (w_avl_elig && w_scn_gnt && !w_starved) begin
         r_starve <= r_starve + 3'd1;
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_scan_data <= 32'h0;
      end else if (w_scan_ret) begin
         r_scan_data <= w_scan_word;
      end
   end

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Scoreboard bench for vram_port_arbiter with a registered VRAM model.
// Expected read data is queued at issue and checked on return.
module tb_vram_port_arbiter;
   import vram_pkg::*;

   logic        CLK = 1'b0;
   logic        RESET_N;
   logic        AVL_CS, AVL_READ, AVL_WRITE;
   logic [9:0]  AVL_ADDR;
   logic [3:0]  AVL_BYTE_EN;
   logic [31:0] AVL_WRITEDATA;
   logic [31:0] AVL_READDATA;
   logic        AVL_WAITREQUEST;
   logic        SCAN_REQ;
   logic [9:0]  SCAN_ADDR;
   logic        SCAN_ACK, SCAN_VALID;
   logic [31:0] SCAN_DATA;
   logic [9:0]  RAM_ADDR;
   logic        RAM_WREN, RAM_RDEN;
   logic [3:0]  RAM_BYTE_EN;
   logic [31:0] RAM_WDATA;
   logic [31:0] RAM_RDATA = 32'h0;

   logic [31:0] ram     [0:1023];
   logic [31:0] ref_mem [0:1023];
   logic [31:0] exp_scan [$];
   logic [31:0] exp_avl  [$];
   int n_cmp = 0;
   int n_err = 0;

   vram_port_arbiter dut (
      .CLK(CLK), .RESET_N(RESET_N),
      .AVL_CS(AVL_CS), .AVL_READ(AVL_READ), .AVL_WRITE(AVL_WRITE),
      .AVL_ADDR(AVL_ADDR), .AVL_BYTE_EN(AVL_BYTE_EN),
      .AVL_WRITEDATA(AVL_WRITEDATA), .AVL_READDATA(AVL_READDATA),
      .AVL_WAITREQUEST(AVL_WAITREQUEST),
      .SCAN_REQ(SCAN_REQ), .SCAN_ADDR(SCAN_ADDR), .SCAN_ACK(SCAN_ACK),
      .SCAN_VALID(SCAN_VALID), .SCAN_DATA(SCAN_DATA),
      .RAM_ADDR(RAM_ADDR), .RAM_WREN(RAM_WREN), .RAM_RDEN(RAM_RDEN),
      .RAM_BYTE_EN(RAM_BYTE_EN), .RAM_WDATA(RAM_WDATA),
      .RAM_RDATA(RAM_RDATA)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) begin
      if (RAM_RDEN) RAM_RDATA <= ram[RAM_ADDR];
      if (RAM_WREN)
         for (int b = 0; b < 4; b++)
            if (RAM_BYTE_EN[b]) ram[RAM_ADDR][b*8 +: 8] <= RAM_WDATA[b*8 +: 8];
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   always @(negedge CLK) begin
      if (RESET_N) begin
         chk("one_acc", 32'(RAM_RDEN & RAM_WREN), 32'h0);
         if (SCAN_VALID) begin
            chk("scan_expected", 32'(exp_scan.size() != 0), 32'h1);
            if (exp_scan.size() != 0) chk("scan_data", SCAN_DATA, exp_scan.pop_front());
         end
         if (AVL_CS && AVL_READ && !AVL_WRITE && !AVL_WAITREQUEST) begin
            chk("avl_expected", 32'(exp_avl.size() != 0), 32'h1);
            if (exp_avl.size() != 0) chk("avl_rdata", AVL_READDATA, exp_avl.pop_front());
         end else begin
            chk("rdata_idle0", AVL_READDATA, 32'h0);
         end
      end
   end

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_in();
      AVL_CS = 1'b0; AVL_READ = 1'b0; AVL_WRITE = 1'b0; SCAN_REQ = 1'b0;
   endtask

   function automatic logic [31:0] model_rd(input logic [9:0] a);
      return (a < 10'd600) ? ref_mem[a] : 32'h0;
   endfunction

   task automatic avl_write(input logic [9:0] a, input logic [31:0] d,
                            input logic [3:0] be);
      int n = 0;
      logic ew;
      ew = (a < 10'd600) && (be != 4'h0);
      cyc();
      AVL_CS = 1'b1; AVL_WRITE = 1'b1; AVL_READ = 1'b0;
      AVL_ADDR = a; AVL_WRITEDATA = d; AVL_BYTE_EN = be;
      #2;
      while (AVL_WAITREQUEST && n < 20) begin cyc(); #2; n++; end
      chk("wr_wait", 32'(AVL_WAITREQUEST), 32'h0);
      chk("wr_wstates", n, 32'h0);
      chk("wr_wren", 32'(RAM_WREN), 32'(ew));
      if (a < 10'd600)
         for (int b = 0; b < 4; b++)
            if (be[b]) ref_mem[a][b*8 +: 8] = d[b*8 +: 8];
      cyc();
      idle_in();
   endtask

   task automatic avl_read(input logic [9:0] a, input int exp_ws);
      int n = 0;
      exp_avl.push_back(model_rd(a));
      cyc();
      AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_WRITE = 1'b0; AVL_ADDR = a;
      AVL_BYTE_EN = 4'hF;
      #2;
      chk("rd_rden", 32'(RAM_RDEN), 32'(a < 10'd600));
      while (AVL_WAITREQUEST && n < 20) begin cyc(); #2; n++; end
      chk("rd_wait", 32'(AVL_WAITREQUEST), 32'h0);
      chk("rd_wstates", n, exp_ws);
      cyc();
      idle_in();
   endtask

   task automatic scan_fetch(input logic [9:0] a);
      int n = 0;
      exp_scan.push_back(model_rd(a));
      cyc();
      SCAN_REQ = 1'b1; SCAN_ADDR = a;
      #2;
      while (!SCAN_ACK && n < 20) begin cyc(); #2; n++; end
      chk("scan_ack", 32'(SCAN_ACK), 32'h1);
      chk("scan_rden", 32'(RAM_RDEN), 32'(a < 10'd600));
      cyc();
      SCAN_REQ = 1'b0;
   endtask

   int ack_e [6]  = '{1, 1, 1, 1, 0, 1};
   int wait_e [6] = '{1, 1, 1, 1, 1, 0};

   initial begin
      for (int i = 0; i < 1024; i++) begin
         ram[i]     = 32'(i) * 32'h9E37_79B1;
         ref_mem[i] = 32'(i) * 32'h9E37_79B1;
      end
      RESET_N = 1'b0;
      idle_in();
      AVL_ADDR = '0; AVL_BYTE_EN = 4'h0; AVL_WRITEDATA = '0; SCAN_ADDR = '0;
      #2;
      chk("rst_valid", 32'(SCAN_VALID), 32'h0);
      chk("rst_sdata", SCAN_DATA, 32'h0);
      chk("rst_wait_idle", 32'(AVL_WAITREQUEST), 32'h0);
      AVL_CS = 1'b1; AVL_READ = 1'b1; SCAN_REQ = 1'b1;
      #1;
      chk("rst_wait_pend", 32'(AVL_WAITREQUEST), 32'h1);
      chk("rst_rden", 32'(RAM_RDEN), 32'h0);
      chk("rst_ack", 32'(SCAN_ACK), 32'h0);
      idle_in();
      #20;
      RESET_N = 1'b1;

      avl_write(10'h005, 32'hDEADBEEF, 4'hF);
      avl_read(10'h005, 1);
      avl_write(10'h005, 32'h11223344, 4'b0101);
      avl_read(10'h005, 1);
      avl_write(10'h005, 32'hFFFFFFFF, 4'h0);
      avl_read(10'h005, 1);
      avl_write(10'h258, 32'hCAFEF00D, 4'hF);
      avl_read(10'h258, 0);
      scan_fetch(10'h3FF);
      scan_fetch(10'h005);

      avl_write(10'h000, 32'hA0A0A0A0, 4'hF);
      avl_write(10'h001, 32'hB1B1B1B1, 4'hF);
      exp_scan.push_back(ref_mem[0]);
      cyc();
      SCAN_REQ = 1'b1; SCAN_ADDR = 10'h000;
      #2;
      chk("il_ack", 32'(SCAN_ACK), 32'h1);
      chk("il_srden", 32'(RAM_RDEN), 32'h1);
      exp_avl.push_back(ref_mem[1]);
      cyc();
      SCAN_REQ = 1'b0;
      AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_WRITE = 1'b0; AVL_ADDR = 10'h001;
      #2;
      chk("il_valid", 32'(SCAN_VALID), 32'h1);
      chk("il_ardn", 32'(RAM_RDEN), 32'h1);
      chk("il_wait1", 32'(AVL_WAITREQUEST), 32'h1);
      cyc();
      #2;
      chk("il_done", 32'(AVL_WAITREQUEST), 32'h0);
      cyc();
      idle_in();
      repeat (2) cyc();
      chk("scan_hold", SCAN_DATA, ref_mem[0]);

      avl_write(10'h010, 32'h5A5A0010, 4'hF);
      exp_avl.push_back(ref_mem[16]);
      cyc();
      SCAN_REQ = 1'b1; SCAN_ADDR = 10'h020;
      AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_WRITE = 1'b0; AVL_ADDR = 10'h010;
      for (int k = 0; k < 6; k++) begin
         #2;
         chk("stv_ack", 32'(SCAN_ACK), ack_e[k]);
         chk("stv_wait", 32'(AVL_WAITREQUEST), wait_e[k]);
         if (k == 4) chk("stv_gnt_addr", 32'(RAM_ADDR), 32'h010);
         if (ack_e[k] != 0) exp_scan.push_back(ref_mem[32]);
         cyc();
      end
      idle_in();
      repeat (2) cyc();

      cyc();
      SCAN_REQ = 1'b1; SCAN_ADDR = 10'h030;
      AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_WRITE = 1'b0; AVL_ADDR = 10'h010;
      #2;
      chk("rs_ack", 32'(SCAN_ACK), 32'h1);
      cyc();
      RESET_N = 1'b0;
      idle_in();
      #1;
      chk("rs_valid", 32'(SCAN_VALID), 32'h0);
      chk("rs_state", 32'(dut.r_state), 32'(ST_IDLE));
      chk("rs_starve", 32'(dut.r_starve), 32'h0);
      repeat (2) cyc();
      RESET_N = 1'b1;
      repeat (3) cyc();
      scan_fetch(10'h031);

      for (int i = 0; i < 40; i++) begin
         logic [9:0] a;
         a = ($urandom_range(0, 7) == 0) ? 10'(600 + $urandom_range(0, 423))
                                         : 10'($urandom_range(0, 15));
         case ($urandom_range(0, 2))
            0: avl_write(a, $urandom, 4'($urandom_range(0, 15)));
            1: avl_read(a, (a < 10'd600) ? 1 : 0);
            default: scan_fetch(a);
         endcase
      end

      repeat (3) cyc();
      chk("scan_q_left", exp_scan.size(), 32'h0);
      chk("avl_q_left", exp_avl.size(), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
